wbxbc_rty_replayer: RTL and testbench



---
 rtl/wbxbc_pkg.sv | 30 +++
 rtl/wbxbc_rty_backoff_cnt.sv | 30 +++
 rtl/wbxbc_rty_replayer.sv | 204 ++++++++++++++++++++
 tb/tb_wbxbc_rty_replayer.sv | 264 ++++++++++++++++++++++++++
 4 files changed

// File: rtl/wbxbc_pkg.sv
// wbxbc_pkg: shared state and response encodings for the WbXbc RTY replay stage.
// Latency: n/a (types and a pure combinational helper only).
// Backpressure: n/a.
package wbxbc_pkg;

  typedef enum logic [1:0] {
    IDLE,
    REQ,
    WAIT,
    BACKOFF
  } state_t;

  typedef enum logic [1:0] {
    NONE,
    ACK,
    ERR,
    RTY
  } resp_t;

  // Simultaneous target responses resolve err > ack > rty.
  function automatic resp_t decode_resp(input logic ack, input logic err, input logic rty);
    resp_t r;
    if (err)      r = ERR;
    else if (ack) r = ACK;
    else if (rty) r = RTY;
    else          r = NONE;
    return r;
  endfunction

endpackage

// File: rtl/wbxbc_rty_backoff_cnt.sv
// wbxbc_rty_backoff_cnt: loadable down-counter giving the idle gap before a replay.
// Latency: done is combinational from the count; load takes effect on the next edge.
// Backpressure: none; dec is ignored once the count reaches zero.
module wbxbc_rty_backoff_cnt #(
  parameter int unsigned WIDTH = 2
) (
  input  logic             clk,
  input  logic             rst_n,
  input  logic             load,
  input  logic [WIDTH-1:0] load_val,
  input  logic             dec,
  output logic             done
);

  logic [WIDTH-1:0] cnt;

  // Load wins over decrement; the count parks at zero.
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      cnt <= '0;
    end else if (load) begin
      cnt <= load_val;
    end else if (dec && (cnt != '0)) begin
      cnt <= cnt - 1'b1;
    end
  end

  assign done = (cnt == '0);

endmodule

// File: rtl/wbxbc_rty_replayer.sv
// wbxbc_rty_replayer: captures one initiator access, replays it on target RTY up to MAX_RETRY times.
// Latency: tgt_stb_o one cycle after acceptance; itr response one cycle after the target response.
// Backpressure: itr_stall_o high outside IDLE; tgt_stall_i holds REQ. WBXBC_RTY_BACKOFF_EN adds a RETRY_DELAY gap before replays.
module wbxbc_rty_replayer
  import wbxbc_pkg::*;
#(
  parameter int unsigned ADR_WIDTH   = 16,
  parameter int unsigned DAT_WIDTH   = 16,
  parameter int unsigned SEL_WIDTH   = 2,
  parameter int unsigned TGA_WIDTH   = 1,
  parameter int unsigned TGC_WIDTH   = 1,
  parameter int unsigned TGRD_WIDTH  = 1,
  parameter int unsigned TGWD_WIDTH  = 1,
  parameter int unsigned MAX_RETRY   = 3,
  parameter int unsigned RETRY_DELAY = 2
) (
  input  logic                  clk_i,
  input  logic                  sync_rst_n_i,
  input  logic                  itr_cyc_i,
  input  logic                  itr_stb_i,
  input  logic                  itr_we_i,
  input  logic                  itr_lock_i,
  input  logic [SEL_WIDTH-1:0]  itr_sel_i,
  input  logic [ADR_WIDTH-1:0]  itr_adr_i,
  input  logic [DAT_WIDTH-1:0]  itr_dat_i,
  input  logic [TGA_WIDTH-1:0]  itr_tga_i,
  input  logic [TGC_WIDTH-1:0]  itr_tgc_i,
  input  logic [TGWD_WIDTH-1:0] itr_tgd_i,
  output logic                  itr_ack_o,
  output logic                  itr_err_o,
  output logic                  itr_rty_o,
  output logic                  itr_stall_o,
  output logic [DAT_WIDTH-1:0]  itr_dat_o,
  output logic [TGRD_WIDTH-1:0] itr_tgd_o,
  output logic                  tgt_cyc_o,
  output logic                  tgt_stb_o,
  output logic                  tgt_we_o,
  output logic                  tgt_lock_o,
  output logic [SEL_WIDTH-1:0]  tgt_sel_o,
  output logic [ADR_WIDTH-1:0]  tgt_adr_o,
  output logic [DAT_WIDTH-1:0]  tgt_dat_o,
  output logic [TGA_WIDTH-1:0]  tgt_tga_o,
  output logic [TGC_WIDTH-1:0]  tgt_tgc_o,
  output logic [TGWD_WIDTH-1:0] tgt_tgd_o,
  input  logic                  tgt_ack_i,
  input  logic                  tgt_err_i,
  input  logic                  tgt_rty_i,
  input  logic                  tgt_stall_i,
  input  logic [DAT_WIDTH-1:0]  tgt_dat_i,
  input  logic [TGRD_WIDTH-1:0] tgt_tgd_i
);

  localparam int unsigned CNT_W = $clog2(MAX_RETRY + 1);
  localparam logic [CNT_W-1:0] MAX_CNT = CNT_W'(MAX_RETRY);

  // Both limits must be at least one; reject bad configurations at elaboration.
  if (MAX_RETRY < 1 || RETRY_DELAY < 1) begin : g_param_check
    $error("wbxbc_rty_replayer: MAX_RETRY and RETRY_DELAY must be >= 1");
  end

  state_t           state, state_nxt;
  resp_t            rsp;
  logic [CNT_W-1:0] retry_cnt, retry_nxt;
  logic             capture, ack_nxt, err_nxt, rty_nxt;
  logic             lock_q;

`ifdef WBXBC_RTY_BACKOFF_EN
  localparam int unsigned DLY_W = $clog2(RETRY_DELAY + 1);
  logic bo_load, bo_done;

  // Loaded with RETRY_DELAY-1 on RTY so BACKOFF lasts exactly RETRY_DELAY cycles.
  wbxbc_rty_backoff_cnt #(.WIDTH(DLY_W)) u_backoff (
    .clk      (clk_i),
    .rst_n    (sync_rst_n_i),
    .load     (bo_load),
    .load_val (DLY_W'(RETRY_DELAY - 1)),
    .dec      (state == BACKOFF),
    .done     (bo_done)
  );
`endif

  assign rsp = decode_resp(tgt_ack_i, tgt_err_i, tgt_rty_i);

  // Next-state, retry bookkeeping and response pulses; abort overrides any response.
  always_comb begin
    state_nxt = state;
    retry_nxt = retry_cnt;
    capture   = 1'b0;
    ack_nxt   = 1'b0;
    err_nxt   = 1'b0;
    rty_nxt   = 1'b0;
`ifdef WBXBC_RTY_BACKOFF_EN
    bo_load   = 1'b0;
`endif
    case (state)
      IDLE: begin
        if (itr_cyc_i && itr_stb_i) begin
          capture   = 1'b1;
          retry_nxt = '0;
          state_nxt = REQ;
        end
      end
      REQ, WAIT: begin
        if (!itr_cyc_i) begin
          retry_nxt = '0;
          state_nxt = IDLE;
        end else begin
          case (rsp)
            ACK: begin
              ack_nxt   = 1'b1;
              state_nxt = IDLE;
            end
            ERR: begin
              err_nxt   = 1'b1;
              state_nxt = IDLE;
            end
            RTY: begin
              if (retry_cnt < MAX_CNT) begin
                retry_nxt = retry_cnt + 1'b1;
`ifdef WBXBC_RTY_BACKOFF_EN
                bo_load   = 1'b1;
                state_nxt = BACKOFF;
`else
                state_nxt = REQ;
`endif
              end else begin
                rty_nxt   = 1'b1;
                state_nxt = IDLE;
              end
            end
            default: begin
              if (state == REQ && !tgt_stall_i) state_nxt = WAIT;
            end
          endcase
        end
      end
`ifdef WBXBC_RTY_BACKOFF_EN
      BACKOFF: begin
        if (!itr_cyc_i) begin
          retry_nxt = '0;
          state_nxt = IDLE;
        end else if (bo_done) begin
          state_nxt = REQ;
        end
      end
`endif
      default: state_nxt = IDLE;
    endcase
  end

  // Control state, retry counter and single-cycle initiator response pulses.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i) begin
      state     <= IDLE;
      retry_cnt <= '0;
      itr_ack_o <= 1'b0;
      itr_err_o <= 1'b0;
      itr_rty_o <= 1'b0;
    end else begin
      state     <= state_nxt;
      retry_cnt <= retry_nxt;
      itr_ack_o <= ack_nxt;
      itr_err_o <= err_nxt;
      itr_rty_o <= rty_nxt;
    end
  end

  // Captured request payload (held for replays) and registered read data.
  always_ff @(posedge clk_i) begin
    if (!sync_rst_n_i) begin
      tgt_we_o  <= 1'b0;
      lock_q    <= 1'b0;
      tgt_sel_o <= '0;
      tgt_adr_o <= '0;
      tgt_dat_o <= '0;
      tgt_tga_o <= '0;
      tgt_tgc_o <= '0;
      tgt_tgd_o <= '0;
      itr_dat_o <= '0;
      itr_tgd_o <= '0;
    end else begin
      if (capture) begin
        tgt_we_o  <= itr_we_i;
        lock_q    <= itr_lock_i;
        tgt_sel_o <= itr_sel_i;
        tgt_adr_o <= itr_adr_i;
        tgt_dat_o <= itr_dat_i;
        tgt_tga_o <= itr_tga_i;
        tgt_tgc_o <= itr_tgc_i;
        tgt_tgd_o <= itr_tgd_i;
      end
      if (ack_nxt) begin
        itr_dat_o <= tgt_dat_i;
        itr_tgd_o <= tgt_tgd_i;
      end
    end
  end

  assign itr_stall_o = (state != IDLE);
  assign tgt_cyc_o   = (state != IDLE);
  assign tgt_stb_o   = (state == REQ);
  assign tgt_lock_o  = lock_q & tgt_cyc_o;

endmodule

// File: tb/tb_wbxbc_rty_replayer.sv
// tb_wbxbc_rty_replayer: directed self-checking bench for the RTY replay stage.
// Latency: inputs driven 1 time unit after each rising edge, outputs sampled there too.
// Backpressure: target stall driven explicitly per step; the target model never stalls by default.
module tb_wbxbc_rty_replayer;

  localparam int MAX_RETRY   = 3;
  localparam int RETRY_DELAY = 2;
`ifdef WBXBC_RTY_BACKOFF_EN
  localparam int GAP = 1 + RETRY_DELAY;
`else
  localparam int GAP = 1;
`endif

  logic        clk = 1'b0;
  logic        rst_n;
  logic        itr_cyc, itr_stb, itr_we, itr_lock;
  logic [1:0]  itr_sel;
  logic [15:0] itr_adr, itr_dat;
  logic        itr_tga, itr_tgc, itr_tgd;
  logic        itr_ack, itr_err, itr_rty, itr_stall;
  logic [15:0] itr_rdat;
  logic        itr_rtgd;
  logic        tgt_cyc, tgt_stb, tgt_we, tgt_lock;
  logic [1:0]  tgt_sel;
  logic [15:0] tgt_adr, tgt_wdat;
  logic        tgt_tga, tgt_tgc, tgt_wtgd;
  logic        tgt_ack, tgt_err, tgt_rty, tgt_stall;
  logic [15:0] tgt_rdat;
  logic        tgt_rtgd;

  int compared   = 0;
  int mismatched = 0;
  int cyc        = 0;
  int issue_cnt  = 0;
  int base;
  int issues;
  logic got_ack, got_rty;

  wbxbc_rty_replayer #(
    .ADR_WIDTH(16), .DAT_WIDTH(16), .SEL_WIDTH(2), .TGA_WIDTH(1), .TGC_WIDTH(1),
    .TGRD_WIDTH(1), .TGWD_WIDTH(1), .MAX_RETRY(MAX_RETRY), .RETRY_DELAY(RETRY_DELAY)
  ) dut (
    .clk_i(clk), .sync_rst_n_i(rst_n),
    .itr_cyc_i(itr_cyc), .itr_stb_i(itr_stb), .itr_we_i(itr_we), .itr_lock_i(itr_lock),
    .itr_sel_i(itr_sel), .itr_adr_i(itr_adr), .itr_dat_i(itr_dat),
    .itr_tga_i(itr_tga), .itr_tgc_i(itr_tgc), .itr_tgd_i(itr_tgd),
    .itr_ack_o(itr_ack), .itr_err_o(itr_err), .itr_rty_o(itr_rty), .itr_stall_o(itr_stall),
    .itr_dat_o(itr_rdat), .itr_tgd_o(itr_rtgd),
    .tgt_cyc_o(tgt_cyc), .tgt_stb_o(tgt_stb), .tgt_we_o(tgt_we), .tgt_lock_o(tgt_lock),
    .tgt_sel_o(tgt_sel), .tgt_adr_o(tgt_adr), .tgt_dat_o(tgt_wdat),
    .tgt_tga_o(tgt_tga), .tgt_tgc_o(tgt_tgc), .tgt_tgd_o(tgt_wtgd),
    .tgt_ack_i(tgt_ack), .tgt_err_i(tgt_err), .tgt_rty_i(tgt_rty), .tgt_stall_i(tgt_stall),
    .tgt_dat_i(tgt_rdat), .tgt_tgd_i(tgt_rtgd)
  );

  always #5 clk = ~clk;

  // Count request phases the target actually takes (strobe without stall).
  always @(negedge clk) begin
    if (tgt_stb === 1'b1 && tgt_stall === 1'b0) issue_cnt++;
  end

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    compared++;
    assert (obs === exp) else begin
      mismatched++;
      $error("FAIL %s: observed 0x%0h expected 0x%0h", tag, obs, exp);
    end
  endtask

  task automatic tick();
    @(posedge clk);
    #1;
    cyc++;
  endtask

  // Present one request for a cycle; the DUT must be in REQ afterwards.
  task automatic start(input logic we, input logic lock, input logic [15:0] adr, input logic [15:0] dat);
    itr_cyc  = 1'b1;
    itr_stb  = 1'b1;
    itr_we   = we;
    itr_lock = lock;
    itr_adr  = adr;
    itr_dat  = dat;
    tick();
    itr_stb  = 1'b0;
    check("accept_stb", tgt_stb, 1'b1);
  endtask

  // Target model: responds the cycle after each accepted strobe, RTY n_rty times then ACK.
  task automatic serve(input int n_rty, input logic [15:0] rdat, input logic [15:0] eadr,
                       input logic [15:0] edat, input logic ewe,
                       output int n_iss, output logic a, output logic r);
    int  rty_left;
    int  last_rty;
    bit  pending;
    bit  have_rty;
    rty_left = n_rty;
    last_rty = 0;
    pending  = 0;
    have_rty = 0;
    n_iss    = 0;
    a        = 1'b0;
    r        = 1'b0;
    tgt_stall = 1'b0;
    for (int c = 0; c < 60; c++) begin
      tgt_ack = 1'b0;
      tgt_rty = 1'b0;
      if (pending) begin
        pending = 0;
        if (rty_left > 0) begin
          tgt_rty  = 1'b1;
          rty_left--;
          last_rty = cyc;
          have_rty = 1;
        end else begin
          tgt_ack  = 1'b1;
          tgt_rdat = rdat;
        end
      end else if (tgt_stb) begin
        n_iss++;
        if (have_rty) check("replay_gap", cyc - last_rty, GAP);
        check("issue_adr", tgt_adr, eadr);
        check("issue_dat", tgt_wdat, edat);
        check("issue_we", tgt_we, ewe);
        pending = 1;
      end
      tick();
      if (itr_ack || itr_rty || itr_err) begin
        a = itr_ack;
        r = itr_rty;
        break;
      end
    end
    tgt_ack = 1'b0;
    tgt_rty = 1'b0;
    check("serve_done", a | r, 1'b1);
  endtask

  initial begin
    rst_n = 1'b0;
    itr_cyc = 0; itr_stb = 0; itr_we = 0; itr_lock = 0;
    itr_sel = 2'b11; itr_adr = 0; itr_dat = 0; itr_tga = 1; itr_tgc = 1; itr_tgd = 1;
    tgt_ack = 0; tgt_err = 0; tgt_rty = 0; tgt_stall = 0; tgt_rdat = 0; tgt_rtgd = 0;

    // Reset values
    tick(); tick();
    check("rst_itr_stall", itr_stall, 1'b0);
    check("rst_tgt_cyc", tgt_cyc, 1'b0);
    check("rst_tgt_stb", tgt_stb, 1'b0);
    check("rst_itr_ack", {itr_ack, itr_err, itr_rty}, 3'b000);
    check("rst_tgt_adr", tgt_adr, 16'h0000);
    check("rst_itr_dat", itr_rdat, 16'h0000);
    rst_n = 1'b1;
    tick();

    // Read at 0x1234, ACK on the second cycle with 0xBEEF
    base = issue_cnt;
    start(1'b0, 1'b0, 16'h1234, 16'h0000);
    check("rd_adr", tgt_adr, 16'h1234);
    check("rd_stall", itr_stall, 1'b1);
    check("rd_tga", tgt_tga, 1'b1);
    tick();
    check("rd_wait_stb", tgt_stb, 1'b0);
    check("rd_wait_cyc", tgt_cyc, 1'b1);
    tgt_ack = 1'b1; tgt_rdat = 16'hBEEF; tgt_rtgd = 1'b1;
    tick();
    tgt_ack = 1'b0;
    check("rd_ack", itr_ack, 1'b1);
    check("rd_dat", itr_rdat, 16'hBEEF);
    check("rd_tgd", itr_rtgd, 1'b1);
    check("rd_ack_stall", itr_stall, 1'b0);
    tick();
    check("rd_ack_once", itr_ack, 1'b0);
    check("rd_issue_cnt", issue_cnt - base, 1);
    itr_cyc = 1'b0;
    tick();

    // Locked write: RTY twice then ACK
    start(1'b1, 1'b1, 16'h00A0, 16'h5A5A);
    check("wr_lock", tgt_lock, 1'b1);
    serve(2, 16'hC0DE, 16'h00A0, 16'h5A5A, 1'b1, issues, got_ack, got_rty);
    check("wr_issues", issues, 3);
    check("wr_ack", got_ack, 1'b1);
    check("wr_no_rty", got_rty, 1'b0);
    check("wr_rdat", itr_rdat, 16'hC0DE);
    tick();
    check("wr_ack_once", itr_ack, 1'b0);
    itr_cyc = 1'b0;
    tick();
    check("wr_lock_idle", tgt_lock, 1'b0);

    // Target always RTY: 1+MAX_RETRY issues then one RTY pulse
    start(1'b0, 1'b0, 16'h0F0F, 16'h0000);
    serve(100, 16'h0000, 16'h0F0F, 16'h0000, 1'b0, issues, got_ack, got_rty);
    check("rty_issues", issues, 1 + MAX_RETRY);
    check("rty_fwd", got_rty, 1'b1);
    check("rty_no_ack", got_ack, 1'b0);
    check("rty_idle_stall", itr_stall, 1'b0);
    check("rty_idle_cyc", tgt_cyc, 1'b0);
    tick();
    check("rty_once", itr_rty, 1'b0);
    itr_cyc = 1'b0;
    tick();

    // Stall holds REQ; simultaneous ERR and ACK give ERR only
    start(1'b0, 1'b0, 16'h2222, 16'h0000);
    tgt_stall = 1'b1;
    tick();
    check("stall_hold_stb", tgt_stb, 1'b1);
    tgt_stall = 1'b0; tgt_err = 1'b1; tgt_ack = 1'b1; tgt_rdat = 16'hDEAD;
    tick();
    tgt_err = 1'b0; tgt_ack = 1'b0;
    check("errack_err", itr_err, 1'b1);
    check("errack_no_ack", itr_ack, 1'b0);
    check("errack_dat_kept", itr_rdat, 16'hC0DE);
    itr_cyc = 1'b0;
    tick();

    // Abort in WAIT while the target acks
    start(1'b0, 1'b0, 16'h3333, 16'h0000);
    tick();
    check("abort_wait_stb", tgt_stb, 1'b0);
    itr_cyc = 1'b0; tgt_ack = 1'b1; tgt_rdat = 16'h1111;
    tick();
    tgt_ack = 1'b0;
    check("abort_no_ack", itr_ack, 1'b0);
    check("abort_cyc", tgt_cyc, 1'b0);
    check("abort_dat_kept", itr_rdat, 16'hC0DE);
    tick();

    // Reset in BACKOFF (plain build: in the replay REQ), then a clean access
    start(1'b1, 1'b1, 16'h4444, 16'h9999);
    tgt_rty = 1'b1;
    tick();
    tgt_rty = 1'b0;
`ifdef WBXBC_RTY_BACKOFF_EN
    check("bo_stb_low", tgt_stb, 1'b0);
`else
    check("replay_stb", tgt_stb, 1'b1);
`endif
    check("bo_cyc_high", tgt_cyc, 1'b1);
    rst_n = 1'b0; itr_cyc = 1'b0;
    tick();
    rst_n = 1'b1;
    check("mrst_cyc", tgt_cyc, 1'b0);
    check("mrst_stb", tgt_stb, 1'b0);
    check("mrst_stall", itr_stall, 1'b0);
    check("mrst_we_lock", {tgt_we, tgt_lock}, 2'b00);
    check("mrst_adr", tgt_adr, 16'h0000);
    check("mrst_rdat", itr_rdat, 16'h0000);
    start(1'b0, 1'b0, 16'h5555, 16'h0000);
    serve(0, 16'h7777, 16'h5555, 16'h0000, 1'b0, issues, got_ack, got_rty);
    check("post_rst_issues", issues, 1);
    check("post_rst_ack", got_ack, 1'b1);
    check("post_rst_dat", itr_rdat, 16'h7777);
    itr_cyc = 1'b0;
    tick();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", compared, mismatched);
    $finish;
  end

endmodule
